// File: rtl/ladybird_irq_controller_pkg.sv
// ladybird_irq_controller_pkg: register offsets and shared types for the interrupt controller
package ladybird_irq_controller_pkg;
  localparam int IRQ_PRIO_W = 3;
  typedef logic [IRQ_PRIO_W-1:0] irq_prio_t;
  localparam logic [7:0] IRQ_PENDING   = 8'h00;
  localparam logic [7:0] IRQ_ENABLE    = 8'h04;
  localparam logic [7:0] IRQ_MODE      = 8'h08;
  localparam logic [7:0] IRQ_THRESHOLD = 8'h0C;
  localparam logic [7:0] IRQ_CLAIM     = 8'h10;
  localparam logic [7:0] IRQ_PRIO_BASE = 8'h20;
endpackage

// File: rtl/ladybird_irq_controller_prio_arbiter.sv
// ladybird_prio_arbiter: picks the highest-priority eligible source, lowest index on ties, as a 1-based id
module ladybird_prio_arbiter #(
  parameter int N = 8,
  parameter int PRIO_W = 3,
  parameter int ID_W = $clog2(N + 1)
) (
  input  logic [N-1:0]        eligible,
  input  logic [N*PRIO_W-1:0] prio,
  output logic                valid,
  output logic [ID_W-1:0]     id
);
  logic [PRIO_W-1:0] best;
  // strict greater-than keeps the earliest index when priorities tie
  always_comb begin
    valid = 1'b0;
    id = '0;
    best = '0;
    for (int i = 0; i < N; i++)
      if (eligible[i] && (!valid || prio[i*PRIO_W +: PRIO_W] > best)) begin
        valid = 1'b1;
        id = ID_W'(i + 1);
        best = prio[i*PRIO_W +: PRIO_W];
      end
  end
endmodule

// File: rtl/ladybird_irq_controller.sv
// ladybird_irq_controller: prioritised interrupt aggregation with claim/complete register port
module ladybird_irq_controller
  import ladybird_irq_controller_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int PRIO_W = IRQ_PRIO_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [N_SRC-1:0]           src,
  input  logic                       reg_req,
  input  logic                       reg_we,
  input  logic [7:0]                 reg_addr,
  input  logic [31:0]                reg_wdata,
  output logic [31:0]                reg_rdata,
  output logic                       reg_ack,
  output logic                       irq,
  input  logic                       complete,
  output logic [$clog2(N_SRC+1)-1:0] claim_id
);
  localparam int ID_W = $clog2(N_SRC + 1);
  logic [N_SRC-1:0] sync [SYNC_STAGES];
  logic [N_SRC-1:0] s_lvl, s_prev, rise, clr, pending, enable, mode, elig;
  logic [PRIO_W-1:0] threshold;
  logic [PRIO_W-1:0] prio [N_SRC];
  logic [N_SRC*PRIO_W-1:0] prio_flat;
  logic arb_valid, best_valid, rd, wr, done, claim_ok, prio_hit;
  logic [ID_W-1:0] arb_id, best_id, active, act_c, claim_val;
  logic [5:0] prio_sel;
  logic [31:0] rd_val;
  assign s_lvl = sync[SYNC_STAGES-1];
  assign rise = s_lvl & ~s_prev;
  assign rd = reg_req && !reg_we;
  assign wr = reg_req && reg_we;
  assign prio_sel = reg_addr[7:2] - 6'd8;
  assign prio_hit = reg_addr >= IRQ_PRIO_BASE && reg_addr[1:0] == 2'b00 && {26'b0, prio_sel} < 32'(N_SRC);
  assign done = complete || (wr && reg_addr == IRQ_CLAIM && reg_wdata == 32'(active));
  assign act_c = done ? '0 : active;
  assign claim_ok = rd && reg_addr == IRQ_CLAIM && best_valid && act_c == '0;
  assign claim_val = claim_ok ? best_id : '0;
  assign irq = best_valid && active == '0;
  assign claim_id = active;
  // eligibility, claim clear mask and read mux
  always_comb begin
    prio_flat = '0;
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      prio_flat[i*PRIO_W +: PRIO_W] = prio[i];
      elig[i] = pending[i] && enable[i] && prio[i] > threshold;
      clr[i] = claim_ok && best_id == ID_W'(i + 1);
    end
    rd_val = reg_addr == IRQ_PENDING ? 32'(pending) :
             reg_addr == IRQ_ENABLE ? 32'(enable) :
             reg_addr == IRQ_MODE ? 32'(mode) :
             reg_addr == IRQ_THRESHOLD ? 32'(threshold) :
             reg_addr == IRQ_CLAIM ? 32'(claim_val) : 32'h0;
    for (int i = 0; i < N_SRC; i++)
      if (prio_hit && prio_sel == 6'(i)) rd_val = 32'(prio[i]);
  end
  ladybird_prio_arbiter #(.N(N_SRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) u_arb (
    .eligible(elig),
    .prio(prio_flat),
    .valid(arb_valid),
    .id(arb_id)
  );
  // synchronisers, pending tracking, configuration registers and service state
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '0;
      s_prev <= '0;
      pending <= '0;
      enable <= '0;
      mode <= '0;
      threshold <= '0;
      for (int i = 0; i < N_SRC; i++) prio[i] <= '0;
      active <= '0;
      best_valid <= 1'b0;
      best_id <= '0;
      reg_ack <= 1'b0;
      reg_rdata <= '0;
    end else begin
      sync[0] <= src;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
      s_prev <= s_lvl;
      pending <= (mode & (rise | (pending & ~clr))) | (~mode & s_lvl);
      if (wr && reg_addr == IRQ_ENABLE) enable <= reg_wdata[N_SRC-1:0];
      if (wr && reg_addr == IRQ_MODE) mode <= reg_wdata[N_SRC-1:0];
      if (wr && reg_addr == IRQ_THRESHOLD) threshold <= reg_wdata[PRIO_W-1:0];
      for (int i = 0; i < N_SRC; i++)
        if (wr && prio_hit && prio_sel == 6'(i)) prio[i] <= reg_wdata[PRIO_W-1:0];
      active <= claim_ok ? best_id : act_c;
      best_valid <= arb_valid;
      best_id <= arb_id;
      reg_ack <= reg_req;
      reg_rdata <= rd ? rd_val : '0;
    end
  end
endmodule

// File: tb/tb_ladybird_irq_controller.sv
// tb_ladybird_irq_controller: directed vector table plus hand-written claim/complete sequences
module tb_ladybird_irq_controller;
  logic clk = 1'b0, nrst = 1'b0, reg_req = 1'b0, reg_we = 1'b0, complete = 1'b0;
  logic [7:0] src = '0, reg_addr = '0;
  logic [31:0] reg_wdata = '0, reg_rdata, d;
  logic reg_ack, irq;
  logic [3:0] claim_id;
  int checks = 0, failures = 0;
  typedef struct packed {
    logic we;
    logic [7:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vec[$];
  ladybird_irq_controller dut (
    .clk(clk), .nrst(nrst), .src(src), .reg_req(reg_req), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .irq(irq), .complete(complete), .claim_id(claim_id)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic we, logic [7:0] a, logic [31:0] w, logic [31:0] e);
    return '{we, a, w, e};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic reg_write(input logic [7:0] a, input logic [31:0] w);
    @(negedge clk);
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = w;
    @(negedge clk);
    reg_req = 1'b0; reg_we = 1'b0;
  endtask
  task automatic reg_read(input logic [7:0] a, output logic [31:0] r);
    @(negedge clk);
    reg_req = 1'b1; reg_we = 1'b0; reg_addr = a;
    @(negedge clk);
    reg_req = 1'b0;
    r = reg_rdata;
    if (reg_ack !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ack: got %0b expected 1", reg_ack);
    end
  endtask
  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] e);
    logic [31:0] r;
    reg_read(a, r);
    check(name, r, e);
  endtask
  task automatic pulse_complete();
    @(negedge clk);
    complete = 1'b1;
    @(negedge clk);
    complete = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) vec.push_back(mk(1'b0, 8'h20 + 8'(4 * i), 32'h0, 32'h0));
    vec.push_back(mk(1'b0, 8'h00, 32'h0, 32'h0));
    vec.push_back(mk(1'b0, 8'h04, 32'h0, 32'h0));
    vec.push_back(mk(1'b0, 8'h08, 32'h0, 32'h0));
    vec.push_back(mk(1'b0, 8'h0C, 32'h0, 32'h0));
    vec.push_back(mk(1'b0, 8'h10, 32'h0, 32'h0));
    vec.push_back(mk(1'b1, 8'h04, 32'hFFFF_FFFF, 32'h0));
    vec.push_back(mk(1'b0, 8'h04, 32'h0, 32'h0000_00FF));
    vec.push_back(mk(1'b1, 8'h0C, 32'h0000_00FF, 32'h0));
    vec.push_back(mk(1'b0, 8'h0C, 32'h0, 32'h0000_0007));
    vec.push_back(mk(1'b1, 8'h2C, 32'h0000_000D, 32'h0));
    vec.push_back(mk(1'b0, 8'h2C, 32'h0, 32'h0000_0005));
    vec.push_back(mk(1'b0, 8'h2D, 32'h0, 32'h0));
    vec.push_back(mk(1'b1, 8'h18, 32'h0000_00AB, 32'h0));
    vec.push_back(mk(1'b0, 8'h18, 32'h0, 32'h0));
    vec.push_back(mk(1'b1, 8'h40, 32'h0000_0003, 32'h0));
    vec.push_back(mk(1'b0, 8'h40, 32'h0, 32'h0));
    vec.push_back(mk(1'b1, 8'h08, 32'h0000_0100, 32'h0));
    vec.push_back(mk(1'b0, 8'h08, 32'h0, 32'h0));
    vec.push_back(mk(1'b1, 8'h04, 32'h0, 32'h0));
    vec.push_back(mk(1'b1, 8'h0C, 32'h0, 32'h0));
    vec.push_back(mk(1'b1, 8'h2C, 32'h0, 32'h0));
    vec.push_back(mk(1'b0, 8'h2C, 32'h0, 32'h0));
    wait_cyc(3);
    check("rst_irq", 32'(irq), 0);
    check("rst_ack", 32'(reg_ack), 0);
    check("rst_rdata", reg_rdata, 0);
    check("rst_claim_id", 32'(claim_id), 0);
    nrst = 1'b1;
    foreach (vec[i])
      if (vec[i].we) reg_write(vec[i].addr, vec[i].wdata);
      else begin
        reg_read(vec[i].addr, d);
        check($sformatf("vec%0d_addr%0h", i, vec[i].addr), d, vec[i].exp);
      end
    @(negedge clk);
    check("ack_one_cycle", 32'(reg_ack), 0);
    check("idle_irq", 32'(irq), 0);
    reg_write(8'h08, 32'h04);
    reg_write(8'h04, 32'h04);
    reg_write(8'h28, 32'h05);
    @(negedge clk);
    src[2] = 1'b1;
    @(negedge clk);
    src[2] = 1'b0;
    wait_cyc(2);
    check("edge_irq_e3", 32'(irq), 0);
    wait_cyc(1);
    check("edge_irq_e4", 32'(irq), 1);
    rd_chk("edge_claim", 8'h10, 3);
    check("edge_irq_after_claim", 32'(irq), 0);
    check("edge_active", 32'(claim_id), 3);
    rd_chk("edge_pending_cleared", 8'h00, 0);
    pulse_complete();
    check("edge_complete_active", 32'(claim_id), 0);
    wait_cyc(3);
    check("edge_irq_stays_low", 32'(irq), 0);
    reg_write(8'h08, 32'h00);
    reg_write(8'h04, 32'h62);
    reg_write(8'h24, 32'h04);
    reg_write(8'h34, 32'h06);
    reg_write(8'h38, 32'h04);
    src = 8'h62;
    wait_cyc(6);
    check("lvl_irq", 32'(irq), 1);
    rd_chk("lvl_claim_a", 8'h10, 6);
    src[5] = 1'b0;
    wait_cyc(5);
    pulse_complete();
    check("lvl_irq_reraise", 32'(irq), 1);
    rd_chk("lvl_claim_b", 8'h10, 2);
    src[1] = 1'b0;
    wait_cyc(5);
    pulse_complete();
    rd_chk("lvl_claim_c", 8'h10, 7);
    src = 8'h00;
    wait_cyc(5);
    pulse_complete();
    wait_cyc(2);
    check("lvl_idle", 32'(irq), 0);
    reg_write(8'h04, 32'h01);
    reg_write(8'h20, 32'h04);
    reg_write(8'h0C, 32'h04);
    src[0] = 1'b1;
    wait_cyc(6);
    check("thr_equal_blocks", 32'(irq), 0);
    reg_write(8'h0C, 32'h03);
    check("thr_not_yet", 32'(irq), 0);
    @(negedge clk);
    check("thr_irq_next", 32'(irq), 1);
    rd_chk("cpl_claim", 8'h10, 1);
    reg_write(8'h10, 32'h05);
    check("cpl_wrong_id", 32'(claim_id), 1);
    rd_chk("cpl_claim_while_active", 8'h10, 0);
    reg_write(8'h10, 32'h01);
    check("cpl_right_id", 32'(claim_id), 0);
    check("cpl_level_reraise", 32'(irq), 1);
    rd_chk("cpl_claim2", 8'h10, 1);
    @(negedge clk);
    complete = 1'b1; reg_req = 1'b1; reg_we = 1'b0; reg_addr = 8'h10;
    @(negedge clk);
    complete = 1'b0; reg_req = 1'b0;
    check("cpl_and_claim_data", reg_rdata, 1);
    check("cpl_and_claim_active", 32'(claim_id), 1);
    pulse_complete();
    src = 8'h00;
    reg_write(8'h04, 32'h04);
    reg_write(8'h08, 32'h04);
    reg_write(8'h0C, 32'h00);
    wait_cyc(5);
    check("e6_idle", 32'(irq), 0);
    @(negedge clk);
    src[2] = 1'b1;
    @(negedge clk);
    src[2] = 1'b0;
    wait_cyc(4);
    check("e6_irq", 32'(irq), 1);
    @(negedge clk);
    src[2] = 1'b1;
    @(negedge clk);
    src[2] = 1'b0;
    rd_chk("e6_claim", 8'h10, 3);
    rd_chk("e6_pending_kept", 8'h00, 32'h04);
    check("e6_active", 32'(claim_id), 3);
    @(negedge clk);
    nrst = 1'b0;
    wait_cyc(2);
    nrst = 1'b1;
    check("rst_mid_irq", 32'(irq), 0);
    check("rst_mid_active", 32'(claim_id), 0);
    @(negedge clk);
    check("rst_mid_irq_next", 32'(irq), 0);
    rd_chk("rst_mid_pending", 8'h00, 0);
    rd_chk("rst_mid_enable", 8'h04, 0);
    rd_chk("rst_mid_prio2", 8'h28, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
